// File: rtl/uart_par_pkg.sv
// Shared UART parity definitions: mode codes, engine state encoding and the mode-mapping helper.
// The uart_tx frame FSM and the RX path reuse these.
package uart_par_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Codes 5..7 are reserved and behave as PAR_NONE.
    function automatic logic par_active(input logic [2:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD) || (mode == PAR_MARK) ||
               (mode == PAR_SPACE);
    endfunction

    function automatic logic par_apply(input logic [2:0] mode, input logic x);
        logic p;
        case (mode)
            PAR_EVEN: p = x;
            PAR_ODD:  p = ~x;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_par_slice.sv
// Masked XOR of one BITS_PER_CYC-wide slice starting at idx; bits at or beyond len fold as 0.
module uart_par_slice #(
    parameter int DATA_W       = 8,
    parameter int BITS_PER_CYC = 1,
    localparam int LEN_W       = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [LEN_W-1:0]  idx,
    input  logic [LEN_W-1:0]  len,
    output logic              x
);

    logic [DATA_W-1:0]       shifted;
    logic [BITS_PER_CYC-1:0] mask;

    // Shifting keeps every read in range; len <= DATA_W masks anything past the word end.
    always_comb begin
        shifted = data >> idx;
        mask    = '0;
        for (int j = 0; j < BITS_PER_CYC; j++) begin
            mask[j] = ({1'b0, idx} + (LEN_W + 1)'(j)) < {1'b0, len};
        end
        x = ^(shifted[BITS_PER_CYC-1:0] & mask);
    end

endmodule

// File: rtl/uart_parity_engine.sv
// Parametrised parity generator/checker: captures a word, folds it BITS_PER_CYC bits per cycle,
// maps the result through the parity mode and holds it on a valid/ack handshake.
module uart_parity_engine
    import uart_par_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int BITS_PER_CYC = 1,
    localparam int LEN_W       = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rest,
    input  logic [DATA_W-1:0] p_data,
    input  logic [LEN_W-1:0]  data_len,
    input  logic [2:0]        par_mode,
    input  logic              chk_bit,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              par_bit,
    output logic              par_err,
    output logic              par_valid,
    input  logic              par_ack,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [2:0]        mode_q, mode_d;
    logic              chk_q, chk_d;
    logic              acc_q, acc_d;
    logic              bit_q, bit_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;

    logic              slice_x;
    logic              fold_x;
    logic              fold_bit;
    logic              last_fold;
    logic [LEN_W-1:0]  len_clamp;

    uart_par_slice #(
        .DATA_W       (DATA_W),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_slice (
        .data (data_q),
        .idx  (idx_q),
        .len  (len_q),
        .x    (slice_x)
    );

    always_comb begin
        len_clamp = data_len;
        if (data_len == '0 || data_len > LEN_W'(DATA_W)) begin
            len_clamp = LEN_W'(DATA_W);
        end
        fold_x    = acc_q ^ slice_x;
        fold_bit  = par_apply(mode_q, fold_x);
        last_fold = ({1'b0, idx_q} + (LEN_W + 1)'(BITS_PER_CYC)) >= {1'b0, len_q};
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        chk_d   = chk_q;
        acc_d   = acc_q;
        bit_d   = bit_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    data_d  = p_data;
                    len_d   = len_clamp;
                    mode_d  = par_mode;
                    chk_d   = chk_bit;
                    acc_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = fold_x;
                idx_d = idx_q + LEN_W'(BITS_PER_CYC);
                if (last_fold) begin
                    bit_d   = fold_bit;
                    err_d   = par_active(mode_q) & (fold_bit != chk_q);
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (par_ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            mode_q  <= PAR_NONE;
            chk_q   <= 1'b0;
            acc_q   <= 1'b0;
            bit_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            chk_q   <= chk_d;
            acc_q   <= acc_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign data_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign par_bit    = bit_q;
    assign par_err    = err_q;
    assign par_valid  = valid_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Bench for uart_parity_engine: an 8-bit/1-bit-per-cycle instance (A) and a 9-bit/4-bit-per-cycle
// instance (B), driven by directed and random frames against a popcount-based reference model.
module tb_uart_parity_engine;

    logic       clk = 1'b0;
    logic       rest = 1'b1;

    logic [7:0] a_data = '0;
    logic [3:0] a_len = '0;
    logic [2:0] a_mode = '0;
    logic       a_chk = 1'b0, a_valid = 1'b0, a_ack = 1'b0;
    logic       a_ready, a_bit, a_err, a_pvalid, a_busy;

    logic [8:0] b_data = '0;
    logic [3:0] b_len = '0;
    logic [2:0] b_mode = '0;
    logic       b_chk = 1'b0, b_valid = 1'b0, b_ack = 1'b0;
    logic       b_ready, b_bit, b_err, b_pvalid, b_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_parity_engine #(.DATA_W(8), .BITS_PER_CYC(1)) dut_a (
        .clk(clk), .rest(rest), .p_data(a_data), .data_len(a_len), .par_mode(a_mode),
        .chk_bit(a_chk), .data_valid(a_valid), .data_ready(a_ready), .par_bit(a_bit),
        .par_err(a_err), .par_valid(a_pvalid), .par_ack(a_ack), .busy(a_busy)
    );

    uart_parity_engine #(.DATA_W(9), .BITS_PER_CYC(4)) dut_b (
        .clk(clk), .rest(rest), .p_data(b_data), .data_len(b_len), .par_mode(b_mode),
        .chk_bit(b_chk), .data_valid(b_valid), .data_ready(b_ready), .par_bit(b_bit),
        .par_err(b_err), .par_valid(b_pvalid), .par_ack(b_ack), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: parity of the popcount of the active bits, then the mode table.
    function automatic logic model_bit(input logic [15:0] d, input int eff, input logic [2:0] m);
        logic [15:0] mask;
        logic        x;
        mask = 16'((32'h1 << eff) - 1);
        x    = ($countones(d & mask) % 2) == 1;
        case (m)
            3'd1:    return x;
            3'd2:    return !x;
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? b_ready : a_ready;
    endfunction
    function automatic logic get_pvalid(input bit sel);
        return sel ? b_pvalid : a_pvalid;
    endfunction
    function automatic logic get_bit(input bit sel);
        return sel ? b_bit : a_bit;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? b_err : a_err;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? b_busy : a_busy;
    endfunction

    task automatic drive(input bit sel, input logic [15:0] d, input logic [3:0] l,
                         input logic [2:0] m, input logic c, input logic v);
        if (sel) begin
            b_data = d[8:0]; b_len = l; b_mode = m; b_chk = c; b_valid = v;
        end else begin
            a_data = d[7:0]; a_len = l; a_mode = m; a_chk = c; a_valid = v;
        end
    endtask

    task automatic set_ack(input bit sel, input logic v);
        if (sel) b_ack = v;
        else     a_ack = v;
    endtask

    task automatic noise(input bit sel);
        drive(sel, 16'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic run_frame(input bit sel, input logic [15:0] d, input logic [3:0] l,
                             input logic [2:0] m, input logic c, input int hold,
                             input bit noisy, input string tag);
        int   dw, bpc, eff, lat, k;
        logic eb, ee;
        dw  = sel ? 9 : 8;
        bpc = sel ? 4 : 1;
        eff = (l == 4'd0 || int'(l) > dw) ? dw : int'(l);
        lat = (eff + bpc - 1) / bpc;
        eb  = model_bit(d, eff, m);
        ee  = (m >= 3'd1 && m <= 3'd4) && (eb != c);
        k = 0;
        while (!get_ready(sel) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, ":ready"}, 32'(get_ready(sel)), 32'd1);
        drive(sel, d, l, m, c, 1'b1);
        @(negedge clk);
        drive(sel, 16'h0, 4'h0, 3'h0, 1'b0, 1'b0);
        check({tag, ":busy"}, 32'(get_busy(sel)), 32'd1);
        k = 0;
        while (!get_pvalid(sel) && k < 40) begin
            if (noisy) noise(sel);
            @(negedge clk);
            k++;
        end
        drive(sel, 16'h0, 4'h0, 3'h0, 1'b0, 1'b0);
        check({tag, ":latency"}, 32'(k), 32'(lat));
        check({tag, ":par_bit"}, 32'(get_bit(sel)), 32'(eb));
        check({tag, ":par_err"}, 32'(get_err(sel)), 32'(ee));
        if (hold > 0) begin
            repeat (hold) begin
                if (noisy) noise(sel);
                @(negedge clk);
            end
            drive(sel, 16'h0, 4'h0, 3'h0, 1'b0, 1'b0);
            check({tag, ":hold_valid"}, 32'(get_pvalid(sel)), 32'd1);
            check({tag, ":hold_bit"}, 32'(get_bit(sel)), 32'(eb));
            check({tag, ":hold_err"}, 32'(get_err(sel)), 32'(ee));
        end
        set_ack(sel, 1'b1);
        @(negedge clk);
        set_ack(sel, 1'b0);
        check({tag, ":ack_idle"}, 32'(get_ready(sel)), 32'd1);
        check({tag, ":ack_valid"}, 32'(get_pvalid(sel)), 32'd0);
        check({tag, ":bit_kept"}, 32'(get_bit(sel)), 32'(eb));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst:a_ready", 32'(a_ready), 32'd1);
        check("rst:a_busy", 32'(a_busy), 32'd0);
        check("rst:a_pvalid", 32'(a_pvalid), 32'd0);
        check("rst:a_bit", 32'(a_bit), 32'd0);
        check("rst:a_err", 32'(a_err), 32'd0);
        check("rst:b_pvalid", 32'(b_pvalid), 32'd0);
        rest = 1'b0;
        @(negedge clk);

        // Directed frames
        run_frame(1'b0, 16'h00A5, 4'd8, 3'd1, 1'b0, 0, 1'b0, "t1_even");
        run_frame(1'b0, 16'h00A5, 4'd8, 3'd2, 1'b0, 0, 1'b0, "t1_odd");
        run_frame(1'b0, 16'h00F1, 4'd5, 3'd1, 1'b0, 0, 1'b0, "t2_len5");
        run_frame(1'b0, 16'h00F1, 4'd0, 3'd1, 1'b0, 0, 1'b0, "t2_len0");
        run_frame(1'b0, 16'h00F1, 4'd12, 3'd2, 1'b1, 0, 1'b0, "t2_len12");
        run_frame(1'b1, 16'h01FF, 4'd9, 3'd1, 1'b0, 0, 1'b0, "t3_partial");
        run_frame(1'b1, 16'h01FF, 4'd6, 3'd2, 1'b1, 0, 1'b0, "t3_len6");
        run_frame(1'b0, 16'h0037, 4'd8, 3'd3, 1'b0, 0, 1'b0, "t4_mark");
        run_frame(1'b0, 16'h0037, 4'd8, 3'd4, 1'b0, 0, 1'b0, "t4_space");
        run_frame(1'b0, 16'h0037, 4'd8, 3'd0, 1'b0, 0, 1'b0, "t4_none");
        run_frame(1'b0, 16'h0037, 4'd8, 3'd7, 1'b1, 0, 1'b0, "t4_mode7");
        run_frame(1'b0, 16'h005A, 4'd8, 3'd2, 1'b1, 10, 1'b1, "t5_hold");

        // Random frames on both instances, with input noise while in flight
        for (int i = 0; i < 30; i++) begin
            run_frame(1'b0, 16'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), 1'b1, "rnd_a");
        end
        for (int i = 0; i < 20; i++) begin
            run_frame(1'b1, 16'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), 1'b1, "rnd_b");
        end

        // Reset mid-CALC discards the frame and clears par_bit left at 1 by the mark frame
        run_frame(1'b0, 16'h0000, 4'd8, 3'd3, 1'b0, 0, 1'b0, "t6_pre");
        drive(1'b0, 16'h00FF, 4'd8, 3'd1, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0, 4'h0, 3'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("t6:mid_busy", 32'(a_busy), 32'd1);
        rest = 1'b1;
        @(negedge clk);
        rest = 1'b0;
        check("t6:rst_ready", 32'(a_ready), 32'd1);
        check("t6:rst_pvalid", 32'(a_pvalid), 32'd0);
        check("t6:rst_bit", 32'(a_bit), 32'd0);
        repeat (10) @(negedge clk);
        check("t6:no_resume", 32'(a_pvalid), 32'd0);

        // Capture request coinciding with reset is dropped
        rest = 1'b1;
        drive(1'b0, 16'h00FF, 4'd8, 3'd1, 1'b0, 1'b1);
        @(negedge clk);
        rest = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 3'h0, 1'b0, 1'b0);
        check("t6:rst_cap_busy", 32'(a_busy), 32'd0);
        repeat (10) @(negedge clk);
        check("t6:rst_cap_pvalid", 32'(a_pvalid), 32'd0);

        run_frame(1'b0, 16'h0081, 4'd8, 3'd2, 1'b0, 0, 1'b0, "t6_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
